crc_rx_cdc_fifo: RTL and testbench
==================================

# crc_rx_cdc_fifo

Clock-domain-crossing receiver that moves CRC results from the clk2 domain into clk_3 using a toggle request / toggle acknowledge handshake, buffers them in a parametrised FIFO, and presents them downstream on a valid/ready interface. It replaces the single-register, pulse-only clk3 output stage. Words are never dropped: when the FIFO is full, the source is back-pressured by withholding the acknowledge.

## Interface
Parameters:
- DW, 60, result width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, synchroniser flops on src_toggle; at least 2.

Ports:
- clk_3  in  1  receiver clock.
- rst_n  in  1  reset, asynchronous, active-low.
- src_data  in  DW  clk2-domain result; held stable by the source from its toggle until src_ack equals src_toggle.
- src_toggle  in  1  clk2-domain request; toggles once per new word.
- src_ack  out  1  clk_3-domain acknowledge toggle, returned to clk2 through that domain's synchroniser.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  DW  FIFO head.
- fifo_level  out  $clog2(DEPTH+1)  current occupancy.
- stall  out  1  high while a pending word waits for space.

## Operation
- src_toggle passes through SYNC_STAGES flops to produce sync_tgl. A request is pending when sync_tgl differs from src_ack.
- Capture FSM, with two states:
  - IDLE:
    - pending with space: write src_data, src_ack <= sync_tgl; stay in IDLE.
    - pending with no space: go to WAIT_SPACE and set stall to 1.
  - WAIT_SPACE:
    - on space: write, toggle src_ack, clear stall, return to IDLE.
    - otherwise stay.
- Space is defined as fifo_level < DEPTH, or a pop occurring in the same cycle. A simultaneous push and pop on a full FIFO succeeds, and the level is unchanged.
- Pop occurs when out_valid and out_ready are both high. out_valid = (fifo_level != 0). out_data is the head entry, read from the registered read pointer.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. Level is kept as a separate counter: +1 on push only, -1 on pop only, unchanged on both or neither.
- At most one capture per cycle. A second source toggle cannot arrive before src_ack returns; the protocol guarantees this.
- Reset values:
  - src_ack = 0, out_valid = 0, fifo_level = 0, stall = 0, FSM = IDLE.
  - out_data = 0; FIFO storage is not reset.
- Reset mid-operation: all contents are discarded. The source shares rst_n and restarts with src_toggle = 0. If src_toggle is already 1 when reset releases, the receiver treats it as a new request.

## Timing
- Latency from src_toggle change (aligned to clk_3) to write: SYNC_STAGES + 1 rising edges.
- src_ack toggles on the same edge as the write.
- out_valid rises on the write edge when the FIFO was empty, i.e. SYNC_STAGES + 1 edges after the toggle.
- Pop takes effect on the edge where out_valid and out_ready are both high. The next head, or deassertion of valid, is visible after that edge.
- Sustained rate is bounded by the handshake round trip, not by the FIFO.

## Configuration
- CRC_RX_ZERO_IDLE_EN:
  - Defined: out_data is forced to all-zero whenever out_valid = 0.
  - Undefined: out_data shows the stale entry at the read pointer when out_valid = 0. This saves the output mux.

## Structure
- Shared package crc_cdc_pkg holds:
  - CRC_DW = 60
  - the default DEPTH and SYNC_STAGES constants
  - the FSM state typedef (IDLE, WAIT_SPACE)
- The existing cdc_sync2 is not reused, because the synchroniser depth is parametrised here.
- Single sub-module crc_rx_fifo: storage, pointers, level counter and the push/pop rules. The FSM and synchroniser stay in the top.

## Test plan
- Single word: toggle src_toggle 0->1 with src_data = 60'h0123456789ABCDE and out_ready = 1. Expect src_ack = 1 and out_valid for one cycle with that data, SYNC_STAGES + 1 edges after the toggle.
- Fill: out_ready = 0, send 5 words with DEPTH = 4. Expect fifo_level = 4, stall = 1, and src_ack not toggled for word 5. Raise out_ready: words 1–5 drain in order, and the fifth ack toggles on the first pop edge.
- Simultaneous push and pop with the FIFO full: level stays at 4 and the written data appears in the correct order.
- Pointer wrap: 20 words through DEPTH = 4 with random out_ready. Output sequence equals input sequence and fifo_level never exceeds 4.
- Assert rst_n low with 3 words buffered. Expect out_valid = 0, fifo_level = 0, src_ack = 0 and out_data = 0 immediately; after release, a new word is delivered normally.
- With CRC_RX_ZERO_IDLE_EN defined, out_data = 0 whenever out_valid = 0. With it undefined, out_data is unconstrained while invalid.

Source files
------------

// File: rtl/crc_cdc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : crc_cdc_pkg
// Description : Shared constants and types for the CRC result receive path
//               (clk2 -> clk_3 crossing, buffering FIFO, capture FSM).
// Contents    : CRC_DW           - CRC result width
//               CRC_DEPTH        - default receive FIFO depth
//               CRC_SYNC_STAGES  - default toggle synchroniser depth
//               cap_state_e      - capture FSM states (IDLE, WAIT_SPACE)
// Revision    : 1.0 - initial release
// ============================================================================
package crc_cdc_pkg;

  localparam int CRC_DW          = 60;
  localparam int CRC_DEPTH       = 4;
  localparam int CRC_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    IDLE       = 1'b0,
    WAIT_SPACE = 1'b1
  } cap_state_e;

endpackage : crc_cdc_pkg
`default_nettype wire

// File: rtl/crc_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : crc_rx_fifo
// Description : Receive FIFO for CRC results. Storage, wrapping read/write
//               pointers, separate occupancy counter and the push/pop rules.
//               The head word is held in a register that is loaded with the
//               word that will sit at the read pointer after each edge, so the
//               output is reset to zero while the storage itself is not.
// Ports       : clk_3      in   receiver clock
//               rst_n      in   asynchronous active-low reset
//               push       in   write wdata this cycle (caller checks space)
//               wdata      in   word to write
//               rd_ready   in   downstream accept
//               rd_valid   out  head entry valid (level != 0)
//               head_data  out  head entry
//               level      out  current occupancy
//               space      out  a push can be accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module crc_rx_fifo
  import crc_cdc_pkg::*;
#(
  parameter int DW    = CRC_DW,
  parameter int DEPTH = CRC_DEPTH
) (
  input  logic                         clk_3,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DW-1:0]                wdata,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [DW-1:0]                head_data,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         space
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] head_q, head_d;
  logic          pop;

  assign rd_valid  = (level_q != '0);
  assign pop       = rd_valid && rd_ready;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign space     = (level_q < LW'(DEPTH)) || pop;
  assign level     = level_q;
  assign head_data = head_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  // The word being written lands exactly at the next read pointer when the
  // FIFO is (or is about to become) empty; bypass it in that case.
  always_comb begin
    head_d = mem_q[rd_ptr_d];
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wdata;
    end
  end

  always_ff @(posedge clk_3 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
    end
  end

  // Storage carries no reset; only the pointers and level define contents.
  always_ff @(posedge clk_3) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule : crc_rx_fifo
`default_nettype wire

// File: rtl/crc_rx_cdc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : crc_rx_cdc_fifo
// Description : Receives CRC results from the clk2 domain over a toggle
//               request / toggle acknowledge handshake, buffers them in a FIFO
//               and presents them on a valid/ready interface in clk_3. When
//               the FIFO is full the acknowledge is withheld, so no word is
//               ever dropped.
// Ports       : clk_3       in   receiver clock
//               rst_n       in   asynchronous active-low reset
//               src_data    in   clk2 result, stable while request pending
//               src_toggle  in   clk2 request toggle
//               src_ack     out  acknowledge toggle back to clk2
//               out_valid   out  FIFO head valid
//               out_ready   in   downstream accept
//               out_data    out  FIFO head
//               fifo_level  out  current occupancy
//               stall       out  pending word waiting for FIFO space
// Config      : CRC_RX_ZERO_IDLE_EN - when defined, out_data is forced to
//               zero while out_valid is low; otherwise the stale head shows.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_rx_cdc_fifo
  import crc_cdc_pkg::*;
#(
  parameter int DW          = CRC_DW,
  parameter int DEPTH       = CRC_DEPTH,
  parameter int SYNC_STAGES = CRC_SYNC_STAGES
) (
  input  logic                         clk_3,
  input  logic                         rst_n,
  input  logic [DW-1:0]                src_data,
  input  logic                         src_toggle,
  output logic                         src_ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DW-1:0]                out_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         stall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_tgl;
  logic                   pending;

  cap_state_e state_q, state_d;
  logic       ack_q, ack_d;
  logic       stall_q, stall_d;

  logic          push;
  logic          space;
  logic [DW-1:0] head_data;

  // Plain shift chain; the first stage is the metastability catcher.
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], src_toggle};
  assign sync_tgl = sync_q[SYNC_STAGES-1];
  assign pending  = sync_tgl ^ ack_q;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    stall_d = stall_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          if (space) begin
            push  = 1'b1;
            ack_d = sync_tgl;
          end else begin
            state_d = WAIT_SPACE;
            stall_d = 1'b1;
          end
        end
      end
      WAIT_SPACE: begin
        // The request cannot be withdrawn, so only space matters here.
        if (space) begin
          push    = 1'b1;
          ack_d   = ~ack_q;
          stall_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        stall_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_3 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      stall_q <= stall_d;
    end
  end

  crc_rx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_3     (clk_3),
    .rst_n     (rst_n),
    .push      (push),
    .wdata     (src_data),
    .rd_ready  (out_ready),
    .rd_valid  (out_valid),
    .head_data (head_data),
    .level     (fifo_level),
    .space     (space)
  );

  assign src_ack = ack_q;
  assign stall   = stall_q;

`ifdef CRC_RX_ZERO_IDLE_EN
  assign out_data = out_valid ? head_data : '0;
`else
  assign out_data = head_data;
`endif

endmodule : crc_rx_cdc_fifo
`default_nettype wire

// File: tb/tb_crc_rx_cdc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_crc_rx_cdc_fifo
// Description : Self-checking bench for crc_rx_cdc_fifo (DW=60, DEPTH=4,
//               SYNC_STAGES=2). A queue-based reference follows every word the
//               source sends and the order in which they must come out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_rx_cdc_fifo;

  localparam int DW    = 60;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic          clk_3 = 1'b0;
  logic          rst_n;
  logic [DW-1:0] src_data;
  logic          src_toggle;
  logic          src_ack;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [2:0]    fifo_level;
  logic          stall;

  int checks   = 0;
  int failures = 0;

  // Words sent but not yet acknowledged, and words inside the FIFO.
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] model_q[$];
  logic          prev_ack;
  bit            pop_pend;

  crc_rx_cdc_fifo #(
    .DW          (DW),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_3      (clk_3),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .src_toggle (src_toggle),
    .src_ack    (src_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .stall      (stall)
  );

  always #5 clk_3 = ~clk_3;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_3);
    #1;
  endtask

  task automatic toggle_word(input logic [DW-1:0] d);
    src_data   = d;
    src_toggle = ~src_toggle;
    sent_q.push_back(d);
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    bit done;
    toggle_word(d);
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (src_ack == src_toggle) done = 1;
    end
    if (!done) chk(0, "ack_timeout", {63'd0, src_ack}, {63'd0, src_toggle});
  endtask

  task automatic drain(input int budget);
    out_ready = 1'b1;
    for (int i = 0; i < budget && (model_q.size() != 0 || sent_q.size() != 0); i++) tick();
    tick();
    chk(model_q.size() == 0 && sent_q.size() == 0, "drain_timeout", 64'(model_q.size()), 64'd0);
  endtask

  // Reference monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_3) begin
    if (!rst_n) begin
      model_q.delete();
      sent_q.delete();
      prev_ack = 1'b0;
      pop_pend = 0;
    end else begin
      if (pop_pend && model_q.size() > 0) void'(model_q.pop_front());
      pop_pend = 0;
      if (src_ack != prev_ack) begin
        if (sent_q.size() > 0) model_q.push_back(sent_q.pop_front());
        else chk(0, "spurious_ack", {63'd0, src_ack}, {63'd0, prev_ack});
        prev_ack = src_ack;
      end
      chk(fifo_level == 3'(model_q.size()), "level", 64'(fifo_level), 64'(model_q.size()));
      chk(out_valid == (model_q.size() != 0), "valid", {63'd0, out_valid}, {63'd0, model_q.size() != 0});
      chk(fifo_level <= 3'(DEPTH), "level_bound", 64'(fifo_level), 64'(DEPTH));
      if (out_valid && out_ready) begin
        if (model_q.size() > 0) chk(out_data == model_q[0], "pop_data", 64'(out_data), 64'(model_q[0]));
        pop_pend = 1;
      end
`ifdef CRC_RX_ZERO_IDLE_EN
      if (!out_valid) chk(out_data == '0, "zero_idle", 64'(out_data), 64'd0);
`endif
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          ready;
  } vec_t;

  vec_t vecs[4];
  logic [DW-1:0] w;

  initial begin
    vecs[0] = '{60'h0123456789ABCDE, 1'b1};
    vecs[1] = '{60'hFFFFFFFFFFFFFFF, 1'b1};
    vecs[2] = '{60'h000000000000001, 1'b0};
    vecs[3] = '{60'hA5A5A5A5A5A5A5A, 1'b1};

    rst_n      = 1'b0;
    src_data   = '0;
    src_toggle = 1'b0;
    out_ready  = 1'b0;
    tick(); tick();
    chk(src_ack == 1'b0, "rst_ack", {63'd0, src_ack}, 64'd0);
    chk(out_valid == 1'b0, "rst_valid", {63'd0, out_valid}, 64'd0);
    chk(fifo_level == 3'd0, "rst_level", 64'(fifo_level), 64'd0);
    chk(stall == 1'b0, "rst_stall", {63'd0, stall}, 64'd0);
    chk(out_data == '0, "rst_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single-word latency: write and ack land SYNC+1 edges after the toggle.
    for (int v = 0; v < 4; v++) begin
      out_ready = vecs[v].ready;
      toggle_word(vecs[v].data);
      for (int e = 0; e < SYNC; e++) tick();
      chk(src_ack != src_toggle, "lat_ack_early", {63'd0, src_ack}, {63'd0, ~src_toggle});
      chk(out_valid == 1'b0, "lat_valid_early", {63'd0, out_valid}, 64'd0);
      tick();
      chk(src_ack == src_toggle, "lat_ack", {63'd0, src_ack}, {63'd0, src_toggle});
      chk(out_valid == 1'b1, "lat_valid", {63'd0, out_valid}, 64'd1);
      chk(out_data == vecs[v].data, "lat_data", 64'(out_data), 64'(vecs[v].data));
      tick();
      chk(out_valid == !vecs[v].ready, "one_cycle_valid", {63'd0, out_valid}, {63'd0, !vecs[v].ready});
      drain(20);
    end

    // Fill, back-pressure the fifth word, release on the first pop edge.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_word(60'h100 + 60'(i));
    chk(fifo_level == 3'd4, "fill_level", 64'(fifo_level), 64'd4);
    toggle_word(60'h1FF);
    for (int i = 0; i < 6; i++) tick();
    chk(stall == 1'b1, "fill_stall", {63'd0, stall}, 64'd1);
    chk(src_ack != src_toggle, "fill_no_ack", {63'd0, src_ack}, {63'd0, ~src_toggle});
    chk(fifo_level == 3'd4, "fill_level_hold", 64'(fifo_level), 64'd4);
    out_ready = 1'b1;
    tick();
    chk(src_ack == src_toggle, "full_pushpop_ack", {63'd0, src_ack}, {63'd0, src_toggle});
    chk(stall == 1'b0, "full_pushpop_stall", {63'd0, stall}, 64'd0);
    chk(fifo_level == 3'd4, "full_pushpop_level", 64'(fifo_level), 64'd4);
    drain(50);

    // Pointer wrap with random back-pressure.
    begin
      bit src_done;
      src_done = 0;
      fork
        begin
          for (int i = 0; i < 20; i++) begin
            w = {$urandom, $urandom};
            send_word(w);
          end
          src_done = 1;
        end
        begin
          for (int i = 0; i < 3000 && !src_done; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
          end
        end
      join
      chk(src_done == 1, "wrap_source_done", {63'd0, src_done}, 64'd1);
      drain(50);
    end

    // Reset with words buffered: contents discarded immediately.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_word(60'h300 + 60'(i));
    chk(fifo_level == 3'd3, "pre_rst_level", 64'(fifo_level), 64'd3);
    rst_n      = 1'b0;
    src_toggle = 1'b0;
    #1;
    chk(out_valid == 1'b0, "mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk(fifo_level == 3'd0, "mid_rst_level", 64'(fifo_level), 64'd0);
    chk(src_ack == 1'b0, "mid_rst_ack", {63'd0, src_ack}, 64'd0);
    chk(out_data == '0, "mid_rst_data", 64'(out_data), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send_word(60'hCAFE);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=%0t required<500000", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_crc_rx_cdc_fifo
`default_nettype wire
